// File: rtl/sync_width_fifo.sv
// sync_width_fifo: single-clock FIFO with power-of-two width conversion
// between the write side (DIN_WIDTH) and the read side (DOUT_WIDTH).
// Storage is kept in units of the narrower width; a write stores WU units,
// a read gathers RU units, most-significant slice first in both directions.
// Optional feature macro: SYNC_WIDTH_FIFO_ERR_EN enables the sticky
// overflow/underflow error flags (tied to 0 when undefined).
module sync_width_fifo #(
  parameter int DIN_WIDTH   = 16,
  parameter int DOUT_WIDTH  = 32,
  parameter int DEPTH_UNITS = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [DIN_WIDTH-1:0]           din,
  output logic                           full,
  output logic                           almost_full,
  input  logic                           rd_en,
  output logic [DOUT_WIDTH-1:0]          dout,
  output logic                           rd_valid,
  output logic                           empty,
  output logic [$clog2(DEPTH_UNITS):0]   level,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int UNIT = (DIN_WIDTH < DOUT_WIDTH) ? DIN_WIDTH : DOUT_WIDTH;
  localparam int WU   = DIN_WIDTH / UNIT;
  localparam int RU   = DOUT_WIDTH / UNIT;
  localparam int AW   = $clog2(DEPTH_UNITS);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH_UNITS);
  localparam logic [AW:0] WU_L    = (AW+1)'(WU);
  localparam logic [AW:0] RU_L    = (AW+1)'(RU);
  localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL_LEVEL);

  logic [UNIT-1:0]       mem [DEPTH_UNITS];
  logic [AW-1:0]         wp;
  logic [AW-1:0]         rp;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [AW-1:0]         wr_addr [WU];
  logic [UNIT-1:0]       din_unit [WU];
  logic [DOUT_WIDTH-1:0] rd_word;
  logic [AW:0]           level_nxt;

  // Status flags come straight from the registered level.
  assign full        = (DEPTH_L - level) < WU_L;
  assign empty       = level < RU_L;
  assign almost_full = level >= AFULL_L;
  assign wr_acc      = wr_en & ~full;
  assign rd_acc      = rd_en & ~empty;

  // Split the write word into units, MS slice first, at consecutive wrapping addresses.
  always_comb begin
    for (int i = 0; i < WU; i++) begin
      wr_addr[i]  = wp + AW'(i);
      din_unit[i] = din[DIN_WIDTH-1-i*UNIT -: UNIT];
    end
  end

  // Gather RU units starting at rp; the unit at rp lands in the MS slice.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < RU; i++) begin
      rd_word[DOUT_WIDTH-1-i*UNIT -: UNIT] = mem[rp + AW'(i)];
    end
  end

  // Next occupancy; level never leaves 0..DEPTH_UNITS so AW+1 bits cannot wrap.
  always_comb begin
    level_nxt = level;
    if (wr_acc) level_nxt = level_nxt + WU_L;
    if (rd_acc) level_nxt = level_nxt - RU_L;
  end

  // Storage array write port.
  // NOTE: the array has no reset; discarding content only needs the pointers
  // and level cleared, and a reset here would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < WU; i++) begin
        mem[wr_addr[i]] <= din_unit[i];
      end
    end
  end

  // Pointers, occupancy and registered read data.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      dout     <= '0;
      rd_valid <= 1'b0;
    end else begin
      level    <= level_nxt;
      rd_valid <= rd_acc;
      if (wr_acc) wp <= wp + AW'(WU);
      if (rd_acc) begin
        rp   <= rp + AW'(RU);
        dout <= rd_word;
      end
    end
  end

`ifdef SYNC_WIDTH_FIFO_ERR_EN
  // Sticky error flags: set on any request against the blocking flag, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & full)  overflow  <= 1'b1;
      if (rd_en & empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
